// File: rtl/zebra_stop_filter.sv
// Hysteretic temporal filter turning per-frame zebra-crossing verdicts into a stable stop command,
// with a minimum hold time and a detector-stall watchdog.
module zebra_stop_filter #(
  parameter int unsigned ASSERT_FRAMES   = 3,
  parameter int unsigned RELEASE_FRAMES  = 5,
  parameter int unsigned MIN_HOLD_CYCLES = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
  parameter int unsigned MIN_BLOBS       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det_valid,
  input  logic       det_crossing,
  input  logic [7:0] det_blob_count,
  output logic       stop,
  output logic       stop_rise,
  output logic       stop_fall,
  output logic       stale,
  output logic [1:0] state
);

  localparam int unsigned PW = (ASSERT_FRAMES   > 0) ? $clog2(ASSERT_FRAMES + 1)   : 1;
  localparam int unsigned NW = (RELEASE_FRAMES  > 0) ? $clog2(RELEASE_FRAMES + 1)  : 1;
  localparam int unsigned HW = (MIN_HOLD_CYCLES > 0) ? $clog2(MIN_HOLD_CYCLES + 1) : 1;
  localparam int unsigned WW = (TIMEOUT_CYCLES  > 0) ? $clog2(TIMEOUT_CYCLES + 1)  : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    STOPPED   = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_cnt, pos_d;
  logic [NW-1:0] neg_cnt, neg_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [WW-1:0] wd_cnt, wd_d;
  logic          stop_d, stale_d, rise_d, fall_d;
  logic          pos, neg, expire, enter_stop;
  logic [PW-1:0] pos_inc;

  assign pos     = det_valid & det_crossing & (32'(det_blob_count) >= MIN_BLOBS);
  assign neg     = det_valid & ~pos;
  assign pos_inc = pos_cnt + PW'(1);
  assign state   = state_q;

  // Next-state, counter and output logic
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_cnt;
    neg_d      = neg_cnt;
    hold_d     = (hold_cnt != '0) ? hold_cnt - HW'(1) : hold_cnt;
    wd_d       = det_valid ? '0 : ((wd_cnt == WW'(TIMEOUT_CYCLES)) ? wd_cnt : wd_cnt + WW'(1));
    expire     = ~det_valid & (wd_d == WW'(TIMEOUT_CYCLES));
    stale_d    = ~det_valid & (stale | expire);
    enter_stop = 1'b0;

    case (state_q)
      IDLE: begin
        if (pos) begin
          pos_d = PW'(1);
          if (ASSERT_FRAMES <= 1) enter_stop = 1'b1;
          else                    state_d    = ARMING;
        end
      end
      ARMING: begin
        if (pos) begin
          if (pos_inc >= PW'(ASSERT_FRAMES)) enter_stop = 1'b1;
          else                               pos_d      = pos_inc;
        end else if (neg || expire) begin
          state_d = IDLE;
          pos_d   = '0;
        end
      end
      STOPPED: begin
        if (pos) begin
          neg_d = '0;
        end else if (neg) begin
          neg_d = NW'(1);
          if (RELEASE_FRAMES <= 1 && hold_d == '0) begin
            state_d = IDLE;
            neg_d   = '0;
          end else begin
            state_d = RELEASING;
          end
        end
      end
      RELEASING: begin
        if (pos) begin
          state_d = STOPPED;
          neg_d   = '0;
        end else begin
          if (neg && neg_cnt < NW'(RELEASE_FRAMES)) neg_d = neg_cnt + NW'(1);
          // Release may happen on a cycle with no verdict once the hold time runs out
          if (neg_d >= NW'(RELEASE_FRAMES) && hold_d == '0) begin
            state_d = IDLE;
            neg_d   = '0;
          end
        end
      end
    endcase

    if (enter_stop) begin
      state_d = STOPPED;
      hold_d  = HW'(MIN_HOLD_CYCLES);
      neg_d   = '0;
      pos_d   = '0;
    end

    stop_d = (state_d == STOPPED) || (state_d == RELEASING);
    rise_d = stop_d & ~stop;
    fall_d = ~stop_d & stop;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_cnt   <= '0;
      neg_cnt   <= '0;
      hold_cnt  <= '0;
      wd_cnt    <= '0;
      stop      <= 1'b0;
      stop_rise <= 1'b0;
      stop_fall <= 1'b0;
      stale     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_cnt   <= pos_d;
      neg_cnt   <= neg_d;
      hold_cnt  <= hold_d;
      wd_cnt    <= wd_d;
      stop      <= stop_d;
      stop_rise <= rise_d;
      stop_fall <= fall_d;
      stale     <= stale_d;
    end
  end

endmodule
